// File: rtl/mmio_player_hub.sv
// mmio_player_hub: memory-mapped register hub between the processor data port
// and the per-player coprocessors. Processor writes land in shadow registers
// and are copied to the active registers atomically on each frame tick. Live
// per-player status, sticky event flags and a frame counter are readable back.
module mmio_player_hub #(
    parameter int          NUM_PLAYERS = 2,
    parameter logic [31:0] MASS_RST    = 32'h00000010,
    parameter logic [31:0] GRAV_RST    = 32'h00010000,
    parameter logic [31:0] WIND_RST    = 32'h00000010
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [12:0]               address,
    input  logic [31:0]               data_in,
    input  logic                      wren,
    input  logic                      rden,
    output logic [31:0]               data_out,
    output logic                      data_valid,
    output logic                      dmem_wren,
    input  logic [31:0]               dmem_q,
    input  logic                      frame_tick,
    input  logic [32*NUM_PLAYERS-1:0] pos_in,
    input  logic [32*NUM_PLAYERS-1:0] damage_in,
    input  logic [4*NUM_PLAYERS-1:0]  event_in,
    output logic [32*NUM_PLAYERS-1:0] mass_out,
    output logic [32*NUM_PLAYERS-1:0] start_pos_out,
    output logic [32*NUM_PLAYERS-1:0] size_out,
    output logic [NUM_PLAYERS-1:0]    freeze_out,
    output logic [31:0]               gravity_out,
    output logic [31:0]               wind_out
);

    // Per-player shadow (processor side) and active (coprocessor side) copies
    logic [31:0]            r_massSh  [NUM_PLAYERS];
    logic [31:0]            r_startSh [NUM_PLAYERS];
    logic [31:0]            r_sizeSh  [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] r_ctrlSh;
    logic [31:0]            r_mass    [NUM_PLAYERS];
    logic [31:0]            r_start   [NUM_PLAYERS];
    logic [31:0]            r_size    [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] r_freeze;
    logic [3:0]             r_event   [NUM_PLAYERS];

    // Global registers
    logic [31:0] r_gravSh;
    logic [31:0] r_windSh;
    logic [31:0] r_grav;
    logic [31:0] r_wind;
    logic        r_pending;
    logic [31:0] r_frameCount;

    // Read-port registers
    logic [31:0] r_dataOut;
    logic        r_dataValid;
    logic        r_dmemSel;

    // Decode wires
    logic                   w_hubSel;
    logic [3:0]             w_idx;
    logic [3:0]             w_off;
    logic [NUM_PLAYERS-1:0] w_chanHit;
    logic                   w_playerSel;
    logic                   w_globalSel;
    logic                   w_wrAccept;
    logic [NUM_PLAYERS-1:0] w_evClear;
    logic [31:0]            w_rdValue;
    logic [3:0]             w_unusedAddrBits;

    assign w_hubSel         = address[12];
    assign w_idx            = address[11:8];
    assign w_off            = address[3:0];
    assign w_unusedAddrBits = address[7:4];
    assign dmem_wren        = wren & ~address[12];
    assign data_out         = r_dmemSel ? dmem_q : r_dataOut;
    assign data_valid       = r_dataValid;
    assign gravity_out      = r_grav;
    assign wind_out         = r_wind;
    assign freeze_out       = r_freeze;

    // Address decode: which channel is hit and whether a write lands on a shadow
    always_comb begin
        w_chanHit = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            w_chanHit[p] = w_hubSel && (w_idx == 4'(p));
        end
        w_playerSel = |w_chanHit;
        w_globalSel = w_hubSel && (w_idx == 4'hF);
        w_wrAccept  = wren && ((w_playerSel && (w_off == 4'd0 || w_off == 4'd1 ||
                                                w_off == 4'd2 || w_off == 4'd6)) ||
                               (w_globalSel && (w_off == 4'd0 || w_off == 4'd1)));
        w_evClear   = w_chanHit & {NUM_PLAYERS{rden && (w_off == 4'd5)}};
    end

    // Read mux over the pre-write state; unmapped locations read as zero
    always_comb begin
        w_rdValue = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (w_chanHit[p]) begin
                case (w_off)
                    4'd0:    w_rdValue = r_massSh[p];
                    4'd1:    w_rdValue = r_startSh[p];
                    4'd2:    w_rdValue = r_sizeSh[p];
                    4'd3:    w_rdValue = pos_in[32*p +: 32];
                    4'd4:    w_rdValue = damage_in[32*p +: 32];
                    4'd5:    w_rdValue = {28'd0, r_event[p]};
                    4'd6:    w_rdValue = {31'd0, r_ctrlSh[p]};
                    default: w_rdValue = '0;
                endcase
            end
        end
        if (w_globalSel) begin
            case (w_off)
                4'd0:    w_rdValue = r_gravSh;
                4'd1:    w_rdValue = r_windSh;
                4'd2:    w_rdValue = {31'd0, r_pending};
                4'd3:    w_rdValue = r_frameCount;
                default: w_rdValue = '0;
            endcase
        end
    end

    // Flatten the active per-player registers onto the output buses
    always_comb begin
        mass_out      = '0;
        start_pos_out = '0;
        size_out      = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            mass_out[32*p +: 32]      = r_mass[p];
            start_pos_out[32*p +: 32] = r_start[p];
            size_out[32*p +: 32]      = r_size[p];
        end
    end

    // Per-player shadows take writes; active copies take the old shadow on a tick
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                r_massSh[p]  <= MASS_RST;
                r_startSh[p] <= '0;
                r_sizeSh[p]  <= '0;
                r_mass[p]    <= MASS_RST;
                r_start[p]   <= '0;
                r_size[p]    <= '0;
            end
            r_ctrlSh <= '0;
            r_freeze <= '0;
        end else begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (frame_tick) begin
                    r_mass[p]   <= r_massSh[p];
                    r_start[p]  <= r_startSh[p];
                    r_size[p]   <= r_sizeSh[p];
                    r_freeze[p] <= r_ctrlSh[p];
                end
                if (w_wrAccept && w_chanHit[p]) begin
                    case (w_off)
                        4'd0:    r_massSh[p]  <= data_in;
                        4'd1:    r_startSh[p] <= data_in;
                        4'd2:    r_sizeSh[p]  <= data_in;
                        4'd6:    r_ctrlSh[p]  <= data_in[0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Global shadows, commit-pending flag and frame counter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_gravSh     <= GRAV_RST;
            r_windSh     <= WIND_RST;
            r_grav       <= GRAV_RST;
            r_wind       <= WIND_RST;
            r_pending    <= 1'b0;
            r_frameCount <= '0;
        end else begin
            if (frame_tick) begin
                r_grav       <= r_gravSh;
                r_wind       <= r_windSh;
                r_frameCount <= r_frameCount + 32'd1;
            end
            if (w_wrAccept && w_globalSel) begin
                if (w_off == 4'd0) begin
                    r_gravSh <= data_in;
                end else begin
                    r_windSh <= data_in;
                end
            end
            if (w_wrAccept) begin
                r_pending <= 1'b1;
            end else if (frame_tick) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Sticky event flags; a clearing read keeps bits arriving that same cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                r_event[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (w_evClear[p]) begin
                    r_event[p] <= event_in[4*p +: 4];
                end else begin
                    r_event[p] <= r_event[p] | event_in[4*p +: 4];
                end
            end
        end
    end

    // Registered read port: hub data with valid, or a select onto DMEM data
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dataOut   <= '0;
            r_dataValid <= 1'b0;
            r_dmemSel   <= 1'b0;
        end else if (rden) begin
            if (w_hubSel) begin
                r_dataOut   <= w_rdValue;
                r_dataValid <= 1'b1;
                r_dmemSel   <= 1'b0;
            end else begin
                r_dataValid <= 1'b0;
                r_dmemSel   <= 1'b1;
            end
        end else begin
            r_dataValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mmio_player_hub.sv
// tb_mmio_player_hub: directed and randomized checks of mmio_player_hub
// against a register-map model kept as plain arrays of shadow/active words.
module tb_mmio_player_hub;

    localparam int          NP       = 2;
    localparam logic [31:0] MASS_RST = 32'h00000010;
    localparam logic [31:0] GRAV_RST = 32'h00010000;
    localparam logic [31:0] WIND_RST = 32'h00000010;

    logic              clock;
    logic              reset;
    logic [12:0]       address;
    logic [31:0]       data_in;
    logic              wren;
    logic              rden;
    logic [31:0]       data_out;
    logic              data_valid;
    logic              dmem_wren;
    logic [31:0]       dmem_q;
    logic              frame_tick;
    logic [32*NP-1:0]  pos_in;
    logic [32*NP-1:0]  damage_in;
    logic [4*NP-1:0]   event_in;
    logic [32*NP-1:0]  mass_out;
    logic [32*NP-1:0]  start_pos_out;
    logic [32*NP-1:0]  size_out;
    logic [NP-1:0]     freeze_out;
    logic [31:0]       gravity_out;
    logic [31:0]       wind_out;

    mmio_player_hub #(
        .NUM_PLAYERS(NP),
        .MASS_RST   (MASS_RST),
        .GRAV_RST   (GRAV_RST),
        .WIND_RST   (WIND_RST)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address      (address),
        .data_in      (data_in),
        .wren         (wren),
        .rden         (rden),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .dmem_wren    (dmem_wren),
        .dmem_q       (dmem_q),
        .frame_tick   (frame_tick),
        .pos_in       (pos_in),
        .damage_in    (damage_in),
        .event_in     (event_in),
        .mass_out     (mass_out),
        .start_pos_out(start_pos_out),
        .size_out     (size_out),
        .freeze_out   (freeze_out),
        .gravity_out  (gravity_out),
        .wind_out     (wind_out)
    );

    // Free-running clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    // Model: banks 0..NP-1 are players, bank 4 is global; each bank is 16 words
    logic [31:0] sh  [5][16];
    logic [31:0] act [5][16];
    logic [3:0]  mEv [4];
    bit          mPending;
    logic [31:0] mFrame;
    logic [31:0] mDataOut;
    bit          mDmemSel;
    bit          mValid;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int bankOf(input logic [12:0] a);
        int idx;
        idx = int'(a[11:8]);
        if (!a[12])     return -1;
        if (idx < NP)   return idx;
        if (idx == 15)  return 4;
        return -1;
    endfunction

    function automatic bit isWritable(input int b, input int o);
        if (b >= 0 && b < 4) return (o == 0 || o == 1 || o == 2 || o == 6);
        if (b == 4)          return (o == 0 || o == 1);
        return 1'b0;
    endfunction

    function automatic logic [31:0] modelRead(input logic [12:0] a);
        int b, o;
        b = bankOf(a);
        o = int'(a[3:0]);
        if (b < 0) return 32'd0;
        if (b < 4) begin
            if (isWritable(b, o)) return sh[b][o];
            if (o == 3)           return pos_in[32*b +: 32];
            if (o == 4)           return damage_in[32*b +: 32];
            if (o == 5)           return {28'd0, mEv[b]};
            return 32'd0;
        end
        if (o <= 1) return sh[4][o];
        if (o == 2) return {31'd0, mPending};
        if (o == 3) return mFrame;
        return 32'd0;
    endfunction

    task automatic modelReset();
        for (int b = 0; b < 5; b++)
            for (int o = 0; o < 16; o++) sh[b][o] = 32'd0;
        for (int p = 0; p < NP; p++) sh[p][0] = MASS_RST;
        sh[4][0] = GRAV_RST;
        sh[4][1] = WIND_RST;
        act = sh;
        for (int p = 0; p < 4; p++) mEv[p] = 4'd0;
        mPending = 0;
        mFrame   = 32'd0;
        mDataOut = 32'd0;
        mDmemSel = 0;
        mValid   = 0;
    endtask

    // One clock of stimulus: predict from the model, clock the DUT, compare
    task automatic applyStimulus(input bit wr, input bit rd, input logic [12:0] a,
                                 input logic [31:0] d, input bit tick,
                                 input logic [4*NP-1:0] ev, input bit rst);
        int b, o, clr;
        wren = wr; rden = rd; address = a; data_in = d;
        frame_tick = tick; event_in = ev; reset = rst;
        #1;
        checkOutput("dmemWren", {31'd0, dmem_wren}, {31'd0, wr & ~a[12]});
        b   = bankOf(a);
        o   = int'(a[3:0]);
        clr = -1;
        if (rst) begin
            modelReset();
        end else begin
            mValid = 0;
            if (rd) begin
                if (a[12]) begin
                    mDataOut = modelRead(a);
                    mDmemSel = 0;
                    mValid   = 1;
                    if (b >= 0 && b < 4 && o == 5) clr = b;
                end else begin
                    mDmemSel = 1;
                end
            end
            for (int p = 0; p < NP; p++)
                mEv[p] = ((clr == p) ? 4'd0 : mEv[p]) | ev[4*p +: 4];
            if (tick) begin
                act    = sh;
                mFrame = mFrame + 32'd1;
            end
            if (wr && isWritable(b, o)) begin
                sh[b][o] = (b < 4 && o == 6) ? {31'd0, d[0]} : d;
                mPending = 1;
            end else if (tick) begin
                mPending = 0;
            end
        end
        @(posedge clock);
        #1;
        checkOutput("dataValid", {31'd0, data_valid}, {31'd0, mValid});
        checkOutput("dataOut", data_out, mDmemSel ? dmem_q : mDataOut);
        for (int p = 0; p < NP; p++) begin
            checkOutput($sformatf("mass%0d", p),  mass_out[32*p +: 32],      act[p][0]);
            checkOutput($sformatf("start%0d", p), start_pos_out[32*p +: 32], act[p][1]);
            checkOutput($sformatf("size%0d", p),  size_out[32*p +: 32],      act[p][2]);
            checkOutput($sformatf("freeze%0d", p), {31'd0, freeze_out[p]},   {31'd0, act[p][6][0]});
        end
        checkOutput("gravity", gravity_out, act[4][0]);
        checkOutput("wind",    wind_out,    act[4][1]);
        wren = 0; rden = 0; frame_tick = 0; event_in = '0; reset = 0;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 13'h0, 32'h0, 0, '0, 0);
    endtask

    task automatic hubRead(input logic [12:0] a, input logic [4*NP-1:0] ev);
        applyStimulus(0, 1, a, 32'h0, 0, ev, 0);
    endtask

    initial begin
        logic [12:0] a;
        int          pick;
        reset = 1; wren = 0; rden = 0; address = '0; data_in = '0;
        frame_tick = 0; event_in = '0; dmem_q = 32'hDEADBEEF;
        pos_in = {32'h00640032, 32'h00C80096};
        damage_in = {32'd7, 32'd3};
        modelReset();

        // Reset state
        applyStimulus(0, 0, 13'h0, 32'h0, 0, '0, 1);
        applyStimulus(0, 0, 13'h0, 32'h0, 0, '0, 1);
        hubRead(13'h1000, '0);
        checkOutput("rstMassRead", data_out, 32'h10);
        checkOutput("rstMassValid", {31'd0, data_valid}, 32'd1);
        checkOutput("rstGravity", gravity_out, 32'h00010000);
        checkOutput("rstMass1", mass_out[63:32], 32'h10);

        // Shadow commit
        applyStimulus(1, 0, 13'h1000, 32'h0E, 0, '0, 0);
        checkOutput("shadowHeld", mass_out[31:0], 32'h10);
        hubRead(13'h1F02, '0);
        checkOutput("statusPending", data_out, 32'd1);
        applyStimulus(0, 0, 13'h0, 32'h0, 1, '0, 0);
        checkOutput("commitMass", mass_out[31:0], 32'h0E);
        hubRead(13'h1F02, '0);
        checkOutput("statusCleared", data_out, 32'd0);
        hubRead(13'h1F03, '0);
        checkOutput("frameCount1", data_out, 32'd1);

        // Write in the same cycle as a tick
        applyStimulus(1, 0, 13'h1101, 32'h02A900FA, 1, '0, 0);
        checkOutput("sameTickStart", start_pos_out[63:32], 32'd0);
        hubRead(13'h1F02, '0);
        checkOutput("sameTickPending", data_out, 32'd1);
        applyStimulus(0, 0, 13'h0, 32'h0, 1, '0, 0);
        checkOutput("nextTickStart", start_pos_out[63:32], 32'h02A900FA);

        // Sticky clear-on-read events
        applyStimulus(0, 0, 13'h0, 32'h0, 0, 4'b0001, 0);
        idle(); idle(); idle();
        hubRead(13'h1005, '0);
        checkOutput("eventSticky", data_out, 32'h1);
        hubRead(13'h1005, '0);
        checkOutput("eventCleared", data_out, 32'h0);
        hubRead(13'h1005, 4'b0100);
        checkOutput("eventConcurrent", data_out, 32'h0);
        hubRead(13'h1005, '0);
        checkOutput("eventRetained", data_out, 32'h4);

        // Invalid accesses
        applyStimulus(1, 0, 13'h1200, 32'd5, 0, '0, 0);
        hubRead(13'h1F02, '0);
        checkOutput("invalidNoPending", data_out, 32'd0);
        hubRead(13'h1200, '0);
        checkOutput("invalidReadZero", data_out, 32'd0);
        checkOutput("invalidReadValid", {31'd0, data_valid}, 32'd1);
        applyStimulus(1, 0, 13'h1003, 32'h12345678, 0, '0, 0);
        hubRead(13'h1003, '0);
        checkOutput("roPosUnchanged", data_out, 32'h00C80096);

        // Frame counter wrap
        force dut.r_frameCount = 32'hFFFFFFFF;
        #1;
        release dut.r_frameCount;
        mFrame = 32'hFFFFFFFF;
        applyStimulus(0, 0, 13'h0, 32'h0, 1, '0, 0);
        hubRead(13'h1F03, '0);
        checkOutput("frameWrap", data_out, 32'd0);

        // DMEM pass-through
        dmem_q = 32'hCAFEF00D;
        applyStimulus(0, 1, 13'h0010, 32'h0, 0, '0, 0);
        checkOutput("dmemData", data_out, 32'hCAFEF00D);
        checkOutput("dmemValid", {31'd0, data_valid}, 32'd0);
        applyStimulus(1, 0, 13'h0010, 32'h1, 0, '0, 0);

        // Reset mid-operation beats concurrent write, tick and read
        applyStimulus(1, 1, 13'h1F00, 32'h55, 1, 4'b1111, 1);
        checkOutput("midRstGravity", gravity_out, GRAV_RST);
        checkOutput("midRstValid", {31'd0, data_valid}, 32'd0);

        // Randomized traffic over mapped, unmapped and DMEM addresses
        for (int n = 0; n < 600; n++) begin
            for (int p = 0; p < NP; p++) begin
                pos_in[32*p +: 32]    = $urandom;
                damage_in[32*p +: 32] = $urandom;
            end
            dmem_q = $urandom;
            pick = $urandom_range(0, 9);
            a = 13'($urandom);
            if (pick < 8) begin
                a[12] = 1'b1;
                if (pick < 5)      a[11:8] = 4'($urandom_range(0, NP - 1));
                else if (pick < 7) a[11:8] = 4'hF;
                a[3:0] = 4'($urandom_range(0, 7));
            end
            applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, a,
                          (a[3:0] == 4'd6) ? 32'($urandom_range(0, 3)) : 32'($urandom),
                          $urandom_range(0, 7) == 0,
                          ($urandom_range(0, 3) == 0) ? (4*NP)'($urandom) : '0,
                          $urandom_range(0, 99) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mmio_player_hub.md
Name: mmio_player_hub

Overview:
- Parametrised memory-mapped register hub between the processor data port and the per-player coprocessors (physics, collision, attack, VGA).
- Generalises the fixed two-player wiring to NUM_PLAYERS channels.
- Processor writes land in shadow registers and are committed to the coprocessors atomically on a frame tick.
- Live per-player status is readable through the same port, with registered read data, sticky clear-on-read event flags and a frame counter.

Parameters:
- NUM_PLAYERS, 2, number of player channels (1..4).
- MASS_RST, 32'h00000010, reset value of every player MASS register.
- GRAV_RST, 32'h00010000, reset value of GRAVITY.
- WIND_RST, 32'h00000010, reset value of WIND.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- address  in  13  processor byte-free word address.
- data_in  in  32  write data.
- wren  in  1  write strobe.
- rden  in  1  read strobe.
- data_out  out  32  read data.
- data_valid  out  1  high for the cycle data_out holds hub read data.
- dmem_wren  out  1  wren & ~address[12] (combinational).
- dmem_q  in  32  DMEM read data, passed through when a DMEM read is selected.
- frame_tick  in  1  one-cycle commit pulse (vsync).
- pos_in  in  32*NUM_PLAYERS  live positions from physics.
- damage_in  in  32*NUM_PLAYERS  live damage from damage coprocessors.
- event_in  in  4*NUM_PLAYERS  per-player event pulses (hit, KO, land, wall).
- mass_out  out  32*NUM_PLAYERS  committed masses.
- start_pos_out  out  32*NUM_PLAYERS  committed start positions.
- size_out  out  32*NUM_PLAYERS  committed sizes.
- freeze_out  out  NUM_PLAYERS  committed CTRL[0] per player.
- gravity_out  out  32  committed gravity.
- wind_out  out  32  committed wind.

Behaviour:
- Decode:
  - address[12]=0 selects DMEM.
  - address[12]=1 selects the hub: index i=address[11:8], offset o=address[3:0].
- Player space (i<NUM_PLAYERS):
  - o=0 MASS, RW shadow.
  - o=1 START_POS, RW shadow.
  - o=2 SIZE, RW shadow.
  - o=3 POS, RO, reads pos_in[i].
  - o=4 DAMAGE, RO, reads damage_in[i].
  - o=5 EVENT, RO, sticky, clear-on-read.
  - o=6 CTRL, RW shadow; bit0 = freeze, bits 31:1 read 0.
- Global space (i=4'hF):
  - o=0 GRAVITY, RW shadow.
  - o=1 WIND, RW shadow.
  - o=2 STATUS, RO; bit0 = commit pending.
  - o=3 FRAME_COUNT, RO.
- Invalid accesses: writes to RO, unmapped offsets, or i in [NUM_PLAYERS, 4'hE] are ignored. Reads of those addresses return 0 with data_valid=1.
- Reads:
  - Hub read: rden with address[12]=1 registers the selected value. data_out and data_valid appear on the next cycle, so latency is 1.
  - DMEM read: rden with address[12]=0 registers a select so that data_out=dmem_q on the next cycle, with data_valid=0.
  - wren and rden together at the same address: the read returns the pre-write value.
- Commit:
  - frame_tick copies every shadow to its active register; outputs change on the cycle after the tick.
  - pending is set by any accepted shadow write and cleared by frame_tick.
  - A write in the same cycle as frame_tick updates the shadow only, is not committed this tick, and leaves pending=1.
- Events:
  - EVENT[i] |= event_in[i] every cycle.
  - A read of EVENT returns the current value and clears it.
  - Event bits arriving in the same cycle as the clearing read are retained (EVENT <= event_in), not lost.
- FRAME_COUNT: 32-bit, increments on each frame_tick, wraps 32'hFFFFFFFF -> 0.
- Reset values:
  - Shadow and active registers, including outputs: MASS=MASS_RST, GRAVITY=GRAV_RST, WIND=WIND_RST; START_POS, SIZE and CTRL = 0.
  - EVENT=0, pending=0, FRAME_COUNT=0, data_out=0, data_valid=0.
- Reset mid-operation wins over every concurrent write, tick or read.

Test Plan:
- Reset: after reset, read 0x1000 -> data_out=0x10 one cycle later with data_valid=1; gravity_out=0x00010000; mass_out all 0x10.
- Shadow commit: write 0x1000=0x0E -> mass_out[0] stays 0x10 and STATUS=1. Pulse frame_tick -> mass_out[0]=0x0E next cycle, STATUS=0, FRAME_COUNT=1.
- Same-cycle write and tick: write 0x1101=0x02A900FA together with frame_tick -> start_pos_out[1] unchanged, STATUS=1. Next tick -> start_pos_out[1]=0x02A900FA.
- Event sticky: pulse event_in[0]=4'b0001, wait 3 cycles, read 0x1005 -> 0x1. Read again -> 0x0. Read with concurrent event_in[0]=4'b0100 -> returns 0, next read -> 0x4.
- Invalid access with NUM_PLAYERS=2: write 0x1200=5 ignored and STATUS unchanged; read 0x1200 -> 0 with data_valid=1. Write 0x1003 ignored.
- Frame counter wrap: force FRAME_COUNT to 0xFFFFFFFF, then one tick -> read 0x1F03 = 0. Separately, DMEM read at 0x0010 -> data_out=dmem_q with data_valid=0, and dmem_wren follows wren only when address[12]=0.
